button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Upstream front end for pwm_buzzer; turns the raw active-low board keys into clean single-cycle step requests.
- Its add_pulse and sub_pulse outputs drive pwm_buzzer's button_add and button_sub inputs.
- Per key: 2-flop synchronizer, counter-based debounce FSM, press-edge pulse generation.
- Rejects contact bounce and simultaneous-press conflicts.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized level must stay stable before acceptance (20 ms at 50 MHz).
- REPEAT_DELAY, 25000000, cycles held before the first auto-repeat pulse (used only with AUTOREPEAT_EN).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (used only with AUTOREPEAT_EN).
- CNT_W, 25, counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk_50  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- key_add_n  input  1  raw "add" key, asynchronous, 0 = pressed
- key_sub_n  input  1  raw "sub" key, asynchronous, 0 = pressed
- add_pulse  output  1  one-cycle "add" step request, to pwm_buzzer button_add
- sub_pulse  output  1  one-cycle "sub" step request, to pwm_buzzer button_sub
- add_held  output  1  debounced "add" level, 1 = pressed
- sub_held  output  1  debounced "sub" level, 1 = pressed

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs 0.
  - Synchronizer flops set to 1 (released).
  - Counters 0; both FSMs in IDLE.
- Synchronizer: 2 flops per key; internal p = ~sync2, so 1 = pressed.
- Per-key FSM, one shared template instantiated twice:
  - IDLE: p=1 -> ARM with counter cleared; otherwise stay.
  - ARM: p=0 -> IDLE, counter cleared. Counter increments while p=1; on reaching DEBOUNCE_CYCLES-1 -> HELD and assert raw_press for one cycle.
  - HELD: held=1. p=0 -> DISARM with counter cleared.
  - DISARM: p=1 -> HELD, counter cleared. Counter increments while p=0; on reaching DEBOUNCE_CYCLES-1 -> IDLE, held=0.
- Latency:
  - Key falling edge to pulse = 2 sync cycles + DEBOUNCE_CYCLES + 1 registered output cycle, i.e. DEBOUNCE_CYCLES+3 clk_50 edges.
  - held rises in the same cycle as the pulse.
- Pulse rules:
  - add_pulse/sub_pulse are registered, exactly 1 cycle wide.
  - One pulse per accepted press; none on release.
- Simultaneous events:
  - raw_press on both keys in the same cycle -> both pulses suppressed. The FSMs still enter HELD.
  - Press on one key while the other is HELD -> the new key pulses normally.
  - add_pulse and sub_pulse are never 1 in the same cycle.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES returns the FSM to its previous stable state; no pulse, no held change.
- Reset mid-operation: all state is lost immediately. A key still held after reset release must be re-debounced and produces one new pulse.
- Counter saturation: counters never wrap; they are cleared on every state transition.

Optional Feature:
- Macro: BUTTON_AUTOREPEAT_EN.
- Defined:
  - In HELD, a repeat counter runs.
  - First extra pulse after REPEAT_DELAY cycles in HELD, then one every REPEAT_PERIOD cycles while still HELD.
  - Repeat counter cleared on leaving HELD.
  - Repeat pulses obey the same both-keys suppression rule: no repeat pulses while both keys are HELD.
- Undefined: repeat logic is absent; exactly one pulse per press.

Test Plan:
All cases use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset: rst_n=0 at t=0 with keys low -> all outputs 0. Release rst_n with key_add_n held low -> one add_pulse exactly 7 cycles after release; add_held=1 from that cycle.
- Clean press: key_add_n 1->0 held 20 cycles -> single add_pulse 7 cycles after the edge. Release -> add_held drops 7 cycles after release; no further pulse.
- Bounce: key_sub_n toggles low 2 cycles / high 1 cycle, repeated 5 times, then stays high -> sub_pulse and sub_held never assert.
- Simultaneous: both keys fall on the same edge and are held 20 cycles -> no pulses; add_held=sub_held=1 after 7 cycles.
- Staggered: add held; sub pressed 10 cycles later -> one add_pulse, then one sub_pulse; never both in one cycle.
- With BUTTON_AUTOREPEAT_EN: add held 30 cycles after acceptance -> pulses at acceptance, +10, +13, +16, ... +28. Without the macro: one pulse only.

Source files
------------

// File: rtl/button_conditioner.sv
// Key front end for pwm_buzzer: per-key synchronizer, debounce FSM and press pulses.
// Optional auto-repeat while a key is held is enabled by defining BUTTON_AUTOREPEAT_EN.

module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic held,
    output logic raw_press,
    output logic rep_req
);
    typedef enum logic [1:0] {IDLE, ARM, HELD, DISARM} state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam longint CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_DELAY)
        ? ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD)
        : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

    if ((CNT_MAX >> CNT_W) != 0) begin : g_cnt_w_too_small
        $error("button_debounce: CNT_W too narrow for the configured cycle counts");
    end

    logic             sync_p0, sync_p1;
    logic             pressed;
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    // Stage boundary: two-flop synchronizer, idles released (1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
        end
    end

    assign pressed = ~sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        raw_press  = 1'b0;
        case (state)
            IDLE: begin
                if (pressed) begin
                    state_next = ARM;
                    cnt_next   = '0;
                end
            end
            ARM: begin
                if (!pressed) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    state_next = HELD;
                    cnt_next   = '0;
                    raw_press  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_next = DISARM;
                    cnt_next   = '0;
                end
            end
            DISARM: begin
                if (pressed) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // A release still being debounced counts as held
    assign held = (state == HELD) || (state == DISARM);

`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rep_cnt, rep_cnt_next;
    logic             rep_phase, rep_phase_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else begin
            rep_cnt   <= rep_cnt_next;
            rep_phase <= rep_phase_next;
        end
    end

    // rep_phase selects the initial delay (0) or the steady repeat period (1)
    always_comb begin
        rep_cnt_next   = '0;
        rep_phase_next = 1'b0;
        rep_req        = 1'b0;
        if (state == HELD && pressed) begin
            rep_phase_next = rep_phase;
            if (rep_cnt == (rep_phase ? RP_LAST : RD_LAST)) begin
                rep_req        = 1'b1;
                rep_phase_next = 1'b1;
            end else begin
                rep_cnt_next = rep_cnt + 1'b1;
            end
        end
    end
`else
    assign rep_req = 1'b0;
`endif
endmodule

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic key_add_n,
    input  logic key_sub_n,
    output logic add_pulse,
    output logic sub_pulse,
    output logic add_held,
    output logic sub_held
);
    logic add_raw, add_rep, sub_raw, sub_rep;
    logic both_held, add_req, sub_req;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD), .CNT_W(CNT_W)
    ) u_add (
        .clk(clk_50), .rst_n(rst_n), .key_n(key_add_n),
        .held(add_held), .raw_press(add_raw), .rep_req(add_rep)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD), .CNT_W(CNT_W)
    ) u_sub (
        .clk(clk_50), .rst_n(rst_n), .key_n(key_sub_n),
        .held(sub_held), .raw_press(sub_raw), .rep_req(sub_rep)
    );

    // A fresh press outranks the other key's repeat; two fresh presses cancel each other
    assign both_held = add_held & sub_held;
    assign add_req   = add_raw | (add_rep & ~both_held & ~sub_raw);
    assign sub_req   = sub_raw | (sub_rep & ~both_held & ~add_raw);

    // Stage boundary: registered one-cycle step requests
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            add_pulse <= 1'b0;
            sub_pulse <= 1'b0;
        end else begin
            add_pulse <= add_req & ~sub_req;
            sub_pulse <= sub_req & ~add_req;
        end
    end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Expectations follow BUTTON_AUTOREPEAT_EN when the bench is built with it.

module tb_button_conditioner;
    logic clk = 1'b0;
    logic rst_n;
    logic key_add_n, key_sub_n;
    logic add_pulse, sub_pulse, add_held, sub_held;

    int vectors = 0;
    int miscompares = 0;
    int add_cnt, sub_cnt, both_cnt, sub_held_seen;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .CNT_W(8)
    ) dut (
        .clk_50(clk), .rst_n(rst_n), .key_add_n(key_add_n), .key_sub_n(key_sub_n),
        .add_pulse(add_pulse), .sub_pulse(sub_pulse), .add_held(add_held), .sub_held(sub_held)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic clear_tally();
        add_cnt = 0; sub_cnt = 0; both_cnt = 0; sub_held_seen = 0;
    endtask

    // One clock edge; outputs are sampled 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
        add_cnt += int'(add_pulse);
        sub_cnt += int'(sub_pulse);
        both_cnt += int'(add_pulse & sub_pulse);
        sub_held_seen += int'(sub_held);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int exp_p;
        rst_n = 1'b0; key_add_n = 1'b0; key_sub_n = 1'b1;
        clear_tally();
        steps(3);
        check("reset_add_pulse", int'(add_pulse), 0);
        check("reset_sub_pulse", int'(sub_pulse), 0);
        check("reset_add_held", int'(add_held), 0);
        check("reset_sub_held", int'(sub_held), 0);

        // Key already down when reset is released
        rst_n = 1'b1;
        clear_tally();
        steps(6);
        check("rst_rel_no_early_pulse", add_cnt, 0);
        check("rst_rel_held_early", int'(add_held), 0);
        step();
        check("rst_rel_pulse_at_7", int'(add_pulse), 1);
        check("rst_rel_held_at_7", int'(add_held), 1);
        step();
        check("rst_rel_pulse_width", int'(add_pulse), 0);
        key_add_n = 1'b1;
        clear_tally();
        steps(6);
        check("rel_held_still_at_6", int'(add_held), 1);
        step();
        check("rel_held_drop_at_7", int'(add_held), 0);
        check("rel_no_pulse", add_cnt, 0);
        steps(5);

        // Clean press, then held for 30 cycles after acceptance
        key_add_n = 1'b0;
        clear_tally();
        steps(6);
        check("press_no_early_pulse", add_cnt, 0);
        step();
        check("press_pulse_at_7", int'(add_pulse), 1);
        check("press_held_at_7", int'(add_held), 1);
        for (int k = 1; k <= 30; k++) begin
            step();
            exp_p = (AUTOREP && (k == 10 || (k >= 13 && (k - 10) % 3 == 0))) ? 1 : 0;
            check($sformatf("hold_pulse_k%0d", k), int'(add_pulse), exp_p);
        end
        key_add_n = 1'b1;
        clear_tally();
        steps(6);
        check("hold_rel_held_at_6", int'(add_held), 1);
        step();
        check("hold_rel_held_drop", int'(add_held), 0);
        check("hold_rel_pulses", add_cnt, AUTOREP ? 1 : 0);
        steps(5);

        // Bounce on sub: low 2 / high 1, five times
        clear_tally();
        for (int r = 0; r < 5; r++) begin
            key_sub_n = 1'b0;
            steps(2);
            key_sub_n = 1'b1;
            step();
        end
        steps(10);
        check("bounce_no_pulse", sub_cnt, 0);
        check("bounce_no_held", sub_held_seen, 0);

        // Simultaneous press of both keys
        key_add_n = 1'b0; key_sub_n = 1'b0;
        clear_tally();
        steps(6);
        check("simul_add_held_at_6", int'(add_held), 0);
        step();
        check("simul_add_held_at_7", int'(add_held), 1);
        check("simul_sub_held_at_7", int'(sub_held), 1);
        steps(13);
        check("simul_no_add_pulse", add_cnt, 0);
        check("simul_no_sub_pulse", sub_cnt, 0);
        key_add_n = 1'b1; key_sub_n = 1'b1;
        steps(12);
        check("simul_rel_add_held", int'(add_held), 0);
        check("simul_rel_sub_held", int'(sub_held), 0);

        // Staggered: add first, sub 10 cycles later
        key_add_n = 1'b0;
        clear_tally();
        steps(7);
        check("stag_add_pulse", int'(add_pulse), 1);
        steps(3);
        key_sub_n = 1'b0;
        steps(7);
        check("stag_sub_pulse", int'(sub_pulse), 1);
        check("stag_add_quiet", int'(add_pulse), 0);
        steps(15);
        check("stag_add_count", add_cnt, 1);
        check("stag_sub_count", sub_cnt, 1);
        check("stag_never_both", both_cnt, 0);
        key_add_n = 1'b1; key_sub_n = 1'b1;
        steps(12);

        // Asynchronous reset mid-press drops everything at once
        key_add_n = 1'b0;
        steps(9);
        check("midrst_held_before", int'(add_held), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_held_cleared", int'(add_held), 0);
        steps(2);
        rst_n = 1'b1;
        clear_tally();
        steps(7);
        check("midrst_repress_pulse", int'(add_pulse), 1);
        check("midrst_repress_count", add_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
